// File: rtl/fetch_pc_if.sv
// Fetch PC unit bus: pipeline control and resolution inputs, fetch/E-stage state outputs.
interface fetch_pc_if #(
   parameter int PC_W = 8
);
   logic            stall;
   logic            prediction;
   logic            branchE;
   logic            takenE;
   logic [PC_W-1:0] targetE;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pcE;
   logic            predE;
   logic            validE;
   logic            mispredict;
   logic [7:0]      mispredict_cnt;

   modport slave (
      input  stall, prediction, branchE, takenE, targetE,
      output pc, pcE, predE, validE, mispredict, mispredict_cnt
   );

   modport master (
      output stall, prediction, branchE, takenE, targetE,
      input  pc, pcE, predE, validE, mispredict, mispredict_cnt
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with F->D->E tracking, E-stage branch resolution and an optional
// direct-mapped BTB enabled by the FETCH_BTB_EN macro.
module fetch_pc_unit #(
   parameter int PC_W      = 8,
   parameter int BTB_IDX_W = 4,
   parameter int RESET_PC  = 0
) (
   input  logic       clk,
   input  logic       reset,
   fetch_pc_if.slave  bus
);
   localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
   localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
   localparam logic [7:0]      CNT_MAX = 8'hFF;

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_d_pc;
   logic [PC_W-1:0] r_d_tgt;
   logic            r_d_pred;
   logic            r_d_valid;
   logic [PC_W-1:0] r_e_pc;
   logic [PC_W-1:0] r_e_tgt;
   logic            r_e_pred;
   logic            r_e_valid;
   logic [7:0]      r_cnt;

   logic            w_predF;
   logic [PC_W-1:0] w_tgtF;
   logic [PC_W-1:0] w_pc_next;
   logic            w_mis;

`ifdef FETCH_BTB_EN
   localparam int TAG_W = PC_W - BTB_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;

   logic                 r_btb_valid [BTB_N];
   logic [TAG_W-1:0]     r_btb_tag   [BTB_N];
   logic [PC_W-1:0]      r_btb_tgt   [BTB_N];
   logic [BTB_IDX_W-1:0] w_rd_idx;
   logic [BTB_IDX_W-1:0] w_wr_idx;
   logic                 w_hit;
   logic                 w_btb_we;

   assign w_rd_idx = r_pc[BTB_IDX_W-1:0];
   assign w_wr_idx = r_e_pc[BTB_IDX_W-1:0];
   assign w_hit    = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == r_pc[PC_W-1:BTB_IDX_W]);
   assign w_btb_we = r_e_valid & bus.branchE & bus.takenE;

   // F-stage prediction: redirect only when the predictor says taken and the BTB knows the target
   always_comb begin
      w_predF = bus.prediction & w_hit;
      if (w_predF) begin
         w_tgtF = r_btb_tgt[w_rd_idx];
      end else begin
         w_tgtF = r_pc + PC_ONE;
      end
   end

   // BTB fill on every resolved-taken branch; reads this cycle still see the old entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BTB_N; i++) begin
            r_btb_valid[i] <= 1'b0;
            r_btb_tag[i]   <= '0;
            r_btb_tgt[i]   <= '0;
         end
      end else if (w_btb_we) begin
         r_btb_valid[w_wr_idx] <= 1'b1;
         r_btb_tag[w_wr_idx]   <= r_e_pc[PC_W-1:BTB_IDX_W];
         r_btb_tgt[w_wr_idx]   <= bus.targetE;
      end
   end
`else
   localparam int unused_btb_idx_w = BTB_IDX_W;
   logic w_unused_prediction;
   assign w_unused_prediction = bus.prediction;

   // Without a BTB the front end always falls through
   always_comb begin
      w_predF = 1'b0;
      w_tgtF  = r_pc + PC_ONE;
   end
`endif

   // Resolution check against what the front end assumed when it fetched the E instruction
   always_comb begin
      w_mis = 1'b0;
      if (r_e_valid && bus.branchE) begin
         if (bus.takenE != r_e_pred) begin
            w_mis = 1'b1;
         end else if (bus.takenE && (r_e_tgt != bus.targetE)) begin
            w_mis = 1'b1;
         end else begin
            w_mis = 1'b0;
         end
      end else begin
         w_mis = 1'b0;
      end
   end

   // Next fetch address: redirect beats stall beats prediction
   always_comb begin
      w_pc_next = r_pc;
      if (w_mis) begin
         if (bus.takenE) begin
            w_pc_next = bus.targetE;
         end else begin
            w_pc_next = r_e_pc + PC_ONE;
         end
      end else if (bus.stall) begin
         w_pc_next = r_pc;
      end else begin
         w_pc_next = w_tgtF;
      end
   end

   // PC and the two pipeline registers that carry the fetch-time assumptions to E
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc      <= PC_RST;
         r_d_pc    <= '0;
         r_d_tgt   <= '0;
         r_d_pred  <= 1'b0;
         r_d_valid <= 1'b0;
         r_e_pc    <= '0;
         r_e_tgt   <= '0;
         r_e_pred  <= 1'b0;
         r_e_valid <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if (w_mis) begin
            r_d_valid <= 1'b0;
         end else if (!bus.stall) begin
            r_d_valid <= 1'b1;
            r_d_pc    <= r_pc;
            r_d_pred  <= w_predF;
            r_d_tgt   <= w_tgtF;
         end
         if (w_mis || bus.stall) begin
            r_e_valid <= 1'b0;
            r_e_pred  <= 1'b0;
         end else begin
            r_e_valid <= r_d_valid;
            r_e_pc    <= r_d_pc;
            r_e_pred  <= r_d_pred;
            r_e_tgt   <= r_d_tgt;
         end
      end
   end

   // Saturating misprediction counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 8'd0;
      end else if (w_mis && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign bus.pc             = r_pc;
   assign bus.pcE            = r_e_pc;
   assign bus.predE          = r_e_pred;
   assign bus.validE         = r_e_valid;
   assign bus.mispredict     = w_mis;
   assign bus.mispredict_cnt = r_cnt;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed table, hand-written corner sequences and random
// stimulus checked against an abstract pipeline/BTB model.
module tb_fetch_pc_unit;
   localparam int PW = 8;
`ifdef FETCH_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   fetch_pc_if #(.PC_W(PW)) bus ();

   fetch_pc_unit #(.PC_W(PW), .BTB_IDX_W(4), .RESET_PC(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // one in-flight instruction as the front end saw it
   typedef struct {
      bit       valid;
      bit [7:0] pc;
      bit       pred;
      bit [7:0] tgt;
   } slot_t;

   slot_t    m_d, m_e;
   bit [7:0] m_pc;
   int       m_cnt;
   bit       m_bv   [16];
   bit [7:0] m_bpc  [16];
   bit [7:0] m_btgt [16];

   typedef struct {
      bit       st, p, b, t;
      bit [7:0] tg;
      bit [7:0] e_pc;
      bit       e_valid;
      bit       e_mis;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc  = 8'd0;
      m_d   = '{valid: 1'b0, pc: 8'd0, pred: 1'b0, tgt: 8'd0};
      m_e   = m_d;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
   endtask

   // called at a negedge; leaves reset asserted across one rising edge and returns at a negedge
   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_pc", bus.pc, 8'd0);
      check("rst_cnt", bus.mispredict_cnt, 8'd0);
      check("rst_validE", bus.validE, 1'b0);
      check("rst_mis", bus.mispredict, 1'b0);
      bus.stall = 1'b0; bus.prediction = 1'b0; bus.branchE = 1'b0;
      bus.takenE = 1'b0; bus.targetE = 8'd0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // one cycle: drive at negedge, check, let the edge happen, advance the model
   task automatic step(input bit st, input bit p, input bit b, input bit t, input bit [7:0] tg,
                       output bit [7:0] o_pc, output bit o_valid, output bit o_mis);
      bit       f_pred, mis;
      bit [7:0] f_tgt, nxt;
      slot_t    nd, ne;
      int       bi;
      bus.stall = st; bus.prediction = p; bus.branchE = b; bus.takenE = t; bus.targetE = tg;
      bi     = m_pc % 16;
      f_pred = BTB_ON && p && m_bv[bi] && (m_bpc[bi] == m_pc);
      f_tgt  = f_pred ? m_btgt[bi] : 8'(m_pc + 1);
      mis    = m_e.valid && b && ((t != m_e.pred) || (t && (m_e.tgt != tg)));
      #1;
      check("pc", bus.pc, m_pc);
      check("validE", bus.validE, m_e.valid);
      check("mispredict", bus.mispredict, mis);
      check("cnt", bus.mispredict_cnt, m_cnt);
      if (m_e.valid) begin
         check("pcE", bus.pcE, m_e.pc);
         check("predE", bus.predE, m_e.pred);
      end
      o_pc = bus.pc; o_valid = bus.validE; o_mis = bus.mispredict;
      @(posedge clk);
      if (mis) nxt = t ? tg : 8'(m_e.pc + 1);
      else if (st) nxt = m_pc;
      else nxt = f_tgt;
      if (BTB_ON && m_e.valid && b && t) begin
         m_bv[m_e.pc % 16]   = 1'b1;
         m_bpc[m_e.pc % 16]  = m_e.pc;
         m_btgt[m_e.pc % 16] = tg;
      end
      ne = (st || mis) ? '{valid: 1'b0, pc: 8'd0, pred: 1'b0, tgt: 8'd0} : m_d;
      nd = m_d;
      if (mis) nd.valid = 1'b0;
      else if (!st) nd = '{valid: 1'b1, pc: m_pc, pred: f_pred, tgt: f_tgt};
      if (mis && (m_cnt < 255)) m_cnt++;
      m_pc = nxt; m_d = nd; m_e = ne;
      @(negedge clk);
   endtask

   initial begin
      vec_t     tbl [11];
      bit [7:0] a_pc;
      bit       a_v, a_m;

      bus.stall = 1'b0; bus.prediction = 1'b0; bus.branchE = 1'b0;
      bus.takenE = 1'b0; bus.targetE = 8'd0;
      @(negedge clk);
      do_reset();

      // reset release, straight-line fetch, then a cold taken branch 0x05 -> 0x20
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h07, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h20, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h21, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h22, 1'b1, 1'b1};
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].st, tbl[i].p, tbl[i].b, tbl[i].t, tbl[i].tg, a_pc, a_v, a_m);
         check($sformatf("tbl%0d_pc", i), a_pc, tbl[i].e_pc);
         check($sformatf("tbl%0d_validE", i), a_v, tbl[i].e_valid);
         check($sformatf("tbl%0d_mis", i), a_m, tbl[i].e_mis);
      end

      // re-fetch 0x05 with prediction=1: a trained BTB jumps straight to 0x20
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("refetch_pc", a_pc, 8'h05);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("predicted_next", a_pc, BTB_ON ? 8'h20 : 8'h06);
      // E holds 0x05; resolve not-taken
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, a_pc, a_v, a_m);
      check("nt_mis", a_m, BTB_ON);
`ifdef FETCH_BTB_EN
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("nt_redirect", a_pc, 8'h06);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, a_pc, a_v, a_m);
      check("back_to_5_mis", a_m, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("btb_kept_pc5", a_pc, 8'h05);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("btb_kept_tgt", a_pc, 8'h20);
`else
      // E holds 0x06 fetched with no BTB: taken branch mispredicts despite prediction=1
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h50, a_pc, a_v, a_m);
      check("nobtb_taken_mis", a_m, 1'b1);
`endif

      // stall alone holds pc; stall with mispredict redirects; 0xFF wraps to 0x00
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("stall_pc_before", a_pc, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("stall_pc_held", a_pc, 8'h01);
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'h40, a_pc, a_v, a_m);
      check("stall_mis", a_m, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("stall_mis_pc", a_pc, 8'h40);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, a_pc, a_v, a_m);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("at_ff", a_pc, 8'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a_pc, a_v, a_m);
      check("wrap_00", a_pc, 8'h00);

      // a run of mispredictions saturates the counter; reset mid-run clears it at once
      for (int i = 0; i < 950; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), a_pc, a_v, a_m);
      end
      check("cnt_saturated", bus.mispredict_cnt, 8'd255);
      do_reset();

      // random traffic; a small target pool lets the BTB get real hits
      for (int i = 0; i < 3000; i++) begin
         bit [7:0] tg;
         tg = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(8'h10 * $urandom_range(1, 4));
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 4) < 2,
                 1'($urandom), tg, a_pc, a_v, a_m);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
